// File: rtl/div_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter_pkg
//  Purpose  : Shared widths, FSM state type and stall encodings for the
//             iterative EX-stage divider.
//  Revision : 1.0  initial release
// ============================================================================
package div_iter_pkg;

    localparam int c_DIV_W     = 32;
    localparam int c_DIV_RES_W = 2 * c_DIV_W;

    // Stall request encodings understood by the pipeline stall controller
    localparam logic c_STOP    = 1'b1;
    localparam logic c_NO_STOP = 1'b0;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div_iter_abs.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter_abs
//  Purpose  : 32-bit conditional two's-complement negate. Used to take
//             absolute values of the operands and to restore result signs.
//  Revision : 1.0  initial release
// ============================================================================
module div_iter_abs
    import div_iter_pkg::*;
(
    input  logic               i_neg,
    input  logic [c_DIV_W-1:0] i_val,
    output logic [c_DIV_W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + 1'b1) : i_val;

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
//  Module   : div_iter
//  Purpose  : Iterative radix-2 restoring divider for DIV/DIVU in EX.
//             Holds the EX stall request while busy and strobes
//             {remainder, quotient} for one cycle when finished.
//  Revision : 1.0  initial release
// ============================================================================
module div_iter
    import div_iter_pkg::*;
(
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   div_start,
    input  logic                   div_signed,
    input  logic [c_DIV_W-1:0]     div_op_a,
    input  logic [c_DIV_W-1:0]     div_op_b,
    input  logic                   div_annul,
    output logic [c_DIV_RES_W-1:0] div_result,
    output logic                   div_ready,
    output logic                   stallreq_for_ex
);

    div_state_t             r_state;
    logic [4:0]             r_cnt;
    logic [c_DIV_W-1:0]     r_rem;
    logic [c_DIV_W-1:0]     r_quo;
    logic [c_DIV_W-1:0]     r_div;
    logic                   r_neg_q;
    logic                   r_neg_r;
    logic [c_DIV_RES_W-1:0] r_result;

    logic [c_DIV_W-1:0]     w_a_abs;
    logic [c_DIV_W-1:0]     w_b_abs;
    logic [c_DIV_W:0]       w_trial;
    logic                   w_ge;
    logic [c_DIV_W-1:0]     w_rem_nxt;
    logic [c_DIV_W-1:0]     w_quo_nxt;
    logic [c_DIV_W-1:0]     w_rem_fix;
    logic [c_DIV_W-1:0]     w_quo_fix;

    // Magnitudes are taken as unsigned 32-bit, so -2^31 maps to 0x80000000
    div_iter_abs u_abs_a (
        .i_neg (div_signed & div_op_a[c_DIV_W-1]),
        .i_val (div_op_a),
        .o_val (w_a_abs)
    );

    div_iter_abs u_abs_b (
        .i_neg (div_signed & div_op_b[c_DIV_W-1]),
        .i_val (div_op_b),
        .o_val (w_b_abs)
    );

    // One restoring step: shift {rem, quo} left, subtract divisor if it fits.
    // The shifted remainder can reach 2*divisor-1, hence the 33-bit trial.
    assign w_trial   = {r_rem, r_quo[c_DIV_W-1]};
    assign w_ge      = (w_trial >= {1'b0, r_div});
    assign w_rem_nxt = w_ge ? (w_trial[c_DIV_W-1:0] - r_div) : w_trial[c_DIV_W-1:0];
    assign w_quo_nxt = {r_quo[c_DIV_W-2:0], w_ge};

    // Sign restoration applied to the final step's outputs on entry to DONE
    div_iter_abs u_fix_q (
        .i_neg (r_neg_q),
        .i_val (w_quo_nxt),
        .o_val (w_quo_fix)
    );

    div_iter_abs u_fix_r (
        .i_neg (r_neg_r),
        .i_val (w_rem_nxt),
        .o_val (w_rem_fix)
    );

    // Control FSM, iteration counter and datapath registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= DIV_IDLE;
            r_cnt    <= 5'd0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (div_annul) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (div_start) begin
                        if (div_op_b == '0) begin
                            r_result <= {div_op_a, {c_DIV_W{1'b1}}};
                            r_state  <= DIV_DONE;
                        end else begin
                            r_rem   <= '0;
                            r_quo   <= w_a_abs;
                            r_div   <= w_b_abs;
                            r_cnt   <= 5'd0;
                            r_neg_q <= div_signed & (div_op_a[c_DIV_W-1] ^ div_op_b[c_DIV_W-1]);
                            r_neg_r <= div_signed & div_op_a[c_DIV_W-1];
                            r_state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_result <= {w_rem_fix, w_quo_fix};
                        r_state  <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    r_state <= DIV_IDLE;
                end
                default: begin
                    r_state <= DIV_IDLE;
                end
            endcase
        end
    end

    // Annul masks the strobe in the same cycle so a flushed op never reports
    assign div_ready       = (r_state == DIV_DONE) & ~div_annul;
    assign div_result      = r_result;
    assign stallreq_for_ex = (div_start & ~div_ready & ~div_annul) ? c_STOP : c_NO_STOP;

endmodule
`default_nettype wire
